// File: rtl/keypad_unit_pkg.sv
// Shared definitions for the keypad unit: data width, key codes, scanner states
// and small decode helpers.
package keypad_unit_pkg;

  localparam int ISA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  // Key code = row*4 + col
  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest low column wins when several are pressed together.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    if (!cols[0]) return 2'd0;
    if (!cols[1]) return 2'd1;
    if (!cols[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] digit_value(input logic [3:0] code);
    case (code)
      KEY_1:   return 4'd1;
      KEY_2:   return 4'd2;
      KEY_3:   return 4'd3;
      KEY_4:   return 4'd4;
      KEY_5:   return 4'd5;
      KEY_6:   return 4'd6;
      KEY_7:   return 4'd7;
      KEY_8:   return 4'd8;
      KEY_9:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner with column synchronizer and press/release debounce; emits a
// one-clock press pulse with the row and column of the accepted key.
module keypad_scanner
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_CYCLES     = 20000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       press,
  output logic [1:0] row_idx,
  output logic [1:0] col_idx
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // colS lags row_out by the two synchronizer flops, so the first samples of
  // each row window still belong to the previous row and are ignored.
  localparam int SETTLE = 2;

  scan_state_t       state_reg;
  logic [3:0]        col_meta_reg;
  logic [3:0]        col_sync_reg;
  logic [3:0]        cap_col_reg;
  logic [1:0]        scan_row_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_SCAN;
      col_meta_reg <= 4'b1111;
      col_sync_reg <= 4'b1111;
      cap_col_reg  <= 4'b1111;
      scan_row_reg <= 2'd0;
      scan_cnt_reg <= '0;
      deb_cnt_reg  <= '0;
      row_out      <= 4'b1110;
      press        <= 1'b0;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
      press        <= 1'b0;
      case (state_reg)
        ST_SCAN: begin
          if (col_sync_reg != 4'b1111 && scan_cnt_reg >= SCAN_W'(SETTLE)) begin
            cap_col_reg <= col_sync_reg;
            deb_cnt_reg <= '0;
            state_reg   <= ST_DEBOUNCE;
          end else if (scan_cnt_reg == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_reg <= '0;
            scan_row_reg <= scan_row_reg + 2'd1;
            row_out      <= row_drive(scan_row_reg + 2'd1);
          end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_sync_reg != cap_col_reg) begin
            scan_cnt_reg <= '0;
            state_reg    <= ST_SCAN;
          end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            press     <= 1'b1;
            state_reg <= ST_PRESSED;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
        ST_PRESSED: begin
          deb_cnt_reg <= '0;
          state_reg   <= ST_RELEASE;
        end
        default: begin
          if (col_sync_reg != 4'b1111) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            scan_cnt_reg <= '0;
            state_reg    <= ST_SCAN;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign row_idx = scan_row_reg;
  assign col_idx = low_col(cap_col_reg);

endmodule

// File: rtl/keypad_unit.sv
// Keypad front end: decodes accepted keys into a decimal accumulator, enter
// pulse, pause toggle and display strobe.
module keypad_unit
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_CYCLES     = 20000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           col_in,
  input  logic                 input_enable,
  output logic [3:0]           row_out,
  output logic [ISA_WIDTH-1:0] input_data,
  output logic                 input_complete,
  output logic                 cpu_pause,
  output logic                 key_strobe,
  output logic [3:0]           key_code
);

  logic                 press;
  logic [1:0]           row_idx;
  logic [1:0]           col_idx;
  logic [3:0]           code;
  logic [ISA_WIDTH-1:0] acc_next;
  logic                 fresh_reg;

  keypad_scanner #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk     (clk),
    .rst     (rst),
    .col_in  (col_in),
    .row_out (row_out),
    .press   (press),
    .row_idx (row_idx),
    .col_idx (col_idx)
  );

  assign code = {row_idx, col_idx};
  // x*10 + d as (x<<3) + (x<<1) + d, wrapping at the data width
  assign acc_next = (input_data << 3) + (input_data << 1) + ISA_WIDTH'(digit_value(code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_data     <= '0;
      fresh_reg      <= 1'b1;
      input_complete <= 1'b0;
      key_strobe     <= 1'b0;
      key_code       <= 4'd0;
      cpu_pause      <= 1'b0;
    end else begin
      key_strobe     <= press;
      input_complete <= 1'b0;
      if (press) begin
        key_code <= code;
        if (is_digit(code)) begin
          if (input_enable) begin
            input_data <= fresh_reg ? ISA_WIDTH'(digit_value(code)) : acc_next;
            fresh_reg  <= 1'b0;
          end
        end else if (code == KEY_HASH) begin
          if (input_enable) begin
            input_complete <= 1'b1;
            fresh_reg      <= 1'b1;
          end
        end else if (code == KEY_A) begin
          cpu_pause <= ~cpu_pause;
        end else if (code == KEY_B) begin
          input_data <= '0;
          fresh_reg  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_unit.sv
// Randomized bench for keypad_unit against a key-level model of the entry rules.
module tb_keypad_unit;

  localparam int SC = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        input_enable = 1'b0;
  logic [31:0] input_data;
  logic        input_complete;
  logic        cpu_pause;
  logic        key_strobe;
  logic [3:0]  key_code;

  int key_held = -1;
  int n_checks = 0;
  int n_pass = 0;
  int strobes = 0;
  int completes = 0;
  bit prev_c = 1'b0;
  bit double_c = 1'b0;

  logic [31:0] m_data;
  bit          m_fresh;
  bit          m_pause;
  bit          m_complete_now;
  int          m_completes;
  string       layout = "123A456B789C*0#D";

  keypad_unit #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk            (clk),
    .rst            (rst),
    .col_in         (col_in),
    .input_enable   (input_enable),
    .row_out        (row_out),
    .input_data     (input_data),
    .input_complete (input_complete),
    .cpu_pause      (cpu_pause),
    .key_strobe     (key_strobe),
    .key_code       (key_code)
  );

  always #5 clk = ~clk;

  // Switch matrix: the held key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'b1111;
    if (key_held >= 0 && row_out[key_held[3:2]] == 1'b0)
      col_in[key_held[1:0]] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_strobe) strobes <= strobes + 1;
    if (input_complete) completes <= completes + 1;
    if (input_complete && prev_c) double_c <= 1'b1;
    prev_c <= input_complete;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_data = 32'd0;
    m_fresh = 1'b1;
    m_pause = 1'b0;
  endtask

  task automatic model_apply(input int k, input bit en);
    byte c;
    c = layout[k];
    m_complete_now = 1'b0;
    if (c >= "0" && c <= "9") begin
      if (en) begin
        if (m_fresh) m_data = 32'(c - "0");
        else         m_data = m_data * 32'd10 + 32'(c - "0");
        m_fresh = 1'b0;
      end
    end else if (c == "#") begin
      if (en) begin
        m_complete_now = 1'b1;
        m_completes++;
        m_fresh = 1'b1;
      end
    end else if (c == "A") begin
      m_pause = ~m_pause;
    end else if (c == "B") begin
      m_data = 32'd0;
      m_fresh = 1'b0;
    end
  endtask

  task automatic wait_strobe(input int k, input bit en);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!key_strobe && t < 300);
    if (!key_strobe) begin
      check_value("strobe_timeout", 32'd0, 32'd1);
    end else begin
      model_apply(k, en);
      check_value("key_code", key_code, k);
      check_value("input_data", input_data, m_data);
      check_value("cpu_pause", cpu_pause, m_pause);
      check_value("input_complete", input_complete, m_complete_now);
      $display("key %s en=%0d data=%0d pause=%0d complete=%0d",
               layout.substr(k, k), en, input_data, cpu_pause, input_complete);
    end
  endtask

  task automatic press(input int k, input bit en, input bit bounce);
    int s0;
    s0 = strobes;
    input_enable = en;
    if (bounce) begin
      repeat (3) begin
        key_held = k;
        repeat (3) @(negedge clk);
        key_held = -1;
        repeat (3) @(negedge clk);
      end
    end
    key_held = k;
    wait_strobe(k, en);
    key_held = -1;
    repeat (DC + 10) @(negedge clk);
    check_value("strobe_once", strobes - s0, 32'd1);
  endtask

  function automatic int key_of_digit(input int d);
    if (d == 0) return 13;
    return ((d - 1) / 3) * 4 + (d - 1) % 3;
  endfunction

  initial begin
    int s;
    int c;
    int t;
    logic [31:0] d0;
    int dig[10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};

    m_completes = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_value("rst_row_out", row_out, 32'hE);
    check_value("rst_input_data", input_data, 32'd0);
    check_value("rst_key_strobe", key_strobe, 32'd0);
    check_value("rst_key_code", key_code, 32'd0);
    check_value("rst_cpu_pause", cpu_pause, 32'd0);
    check_value("rst_input_complete", input_complete, 32'd0);
    rst = 1'b0;

    // 1 2 3 # -> 123
    s = strobes; c = completes;
    press(0, 1'b1, 1'b0);
    press(1, 1'b1, 1'b0);
    press(2, 1'b1, 1'b0);
    press(14, 1'b1, 1'b0);
    check_value("entry_123", input_data, 32'd123);
    check_value("entry_completes", completes - c, 32'd1);
    check_value("entry_strobes", strobes - s, 32'd4);

    // bouncing 5
    press(5, 1'b1, 1'b1);

    // A twice toggles pause and leaves data alone
    d0 = m_data;
    press(3, 1'b1, 1'b0);
    check_value("pause_on", cpu_pause, 32'd1);
    press(3, 1'b1, 1'b0);
    check_value("pause_off", cpu_pause, 32'd0);
    check_value("pause_data_kept", input_data, d0);

    // wraparound at all-ones
    press(7, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) press(key_of_digit(dig[i]), 1'b1, 1'b0);
    check_value("all_ones", input_data, 32'hFFFF_FFFF);
    press(10, 1'b1, 1'b0);
    check_value("wrap_9", input_data, 32'hFFFF_FFFF);
    press(7, 1'b1, 1'b0);
    check_value("clear_b", input_data, 32'd0);

    // input disabled
    s = strobes; c = completes;
    press(4, 1'b0, 1'b0);
    press(14, 1'b0, 1'b0);
    check_value("dis_strobes", strobes - s, 32'd2);
    check_value("dis_completes", completes - c, 32'd0);
    check_value("dis_data", input_data, 32'd0);

    // reset in the middle of debouncing key 7, key held through reset
    press(3, 1'b0, 1'b0);
    press(6, 1'b1, 1'b0);
    s = strobes;
    t = 0;
    while (row_out !== 4'hE && t < 200) begin @(negedge clk); t++; end
    key_held = 8;
    t = 0;
    while (row_out !== 4'hB && t < 200) begin @(negedge clk); t++; end
    check_value("row2_reached", (t < 200) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("arst_row_out", row_out, 32'hE);
    check_value("arst_input_data", input_data, 32'd0);
    check_value("arst_key_strobe", key_strobe, 32'd0);
    check_value("arst_key_code", key_code, 32'd0);
    check_value("arst_cpu_pause", cpu_pause, 32'd0);
    check_value("arst_input_complete", input_complete, 32'd0);
    check_value("arst_no_early_strobe", strobes - s, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    input_enable = 1'b1;
    wait_strobe(8, 1'b1);
    key_held = -1;
    repeat (DC + 10) @(negedge clk);
    check_value("arst_one_strobe", strobes - s, 32'd1);

    // random keys, enables and bounces
    for (int i = 0; i < 30; i++)
      press(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    check_value("complete_never_double", double_c, 32'd0);
    check_value("complete_total", completes, m_completes);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
